// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field against it,
// gates the decoder write/branch strobes and keeps saturating executed/squashed counts.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       cond_i,
    input  logic [3:0]       alu_flags_i,
    input  logic [1:0]       flag_write_i,
    input  logic             pc_src_i,
    input  logic             reg_write_i,
    input  logic             mem_write_i,
    input  logic             stall_i,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             cond_ex_o,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] exec_count_o,
    output logic [CNT_W-1:0] squash_count_o
);

    // flags_reg = {N, Z, C, V}
    logic [3:0]  flags_reg;
    logic [15:0] pass_vec;
    logic        commit;
    logic [1:0]  cnt_inc;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        res = 1'b0;
        case (code)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = ~(n ^ v);
            4'b1011: res = n ^ v;
            4'b1100: res = ~z & ~(n ^ v);
            4'b1101: res = z | (n ^ v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // All sixteen outcomes are evaluated in parallel off the registered flags;
    // the condition field then just selects one, keeping cond_i off the deep path.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cond
            localparam logic [3:0] CODE = gi[3:0];
            assign pass_vec[gi] = eval_cond(CODE, flags_reg);
        end
    endgenerate

    assign cond_ex_o   = pass_vec[cond_i];
    assign commit      = cond_ex_o & ~stall_i;
    assign pc_src_o    = pc_src_i    & commit;
    assign reg_write_o = reg_write_i & commit;
    assign mem_write_o = mem_write_i & commit;
    assign flags_o     = flags_reg;

    // flag_write_i is only inspected once commit is known true, so an undefined
    // write mask on a squashed or stalled instruction cannot reach the register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_reg <= 4'b0000;
        end else if (commit) begin
            if (flag_write_i[1]) flags_reg[3:2] <= alu_flags_i[3:2];
            if (flag_write_i[0]) flags_reg[1:0] <= alu_flags_i[1:0];
        end
    end

    assign cnt_inc[0] = ~stall_i &  cond_ex_o;
    assign cnt_inc[1] = ~stall_i & ~cond_ex_o;

    // Index 0 counts executed instructions, index 1 counts squashed ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) cnt_reg <= '0;
                else       cnt_reg <= cnt_next;
            end
        end
    endgenerate

    assign exec_count_o   = g_cnt[0].cnt_reg;
    assign squash_count_o = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed sequences, a condition-code vector
// table and randomized cycles compared against a behavioural model.
module tb_cond_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [3:0]       cond_i;
    logic [3:0]       alu_flags_i;
    logic [1:0]       flag_write_i;
    logic             pc_src_i;
    logic             reg_write_i;
    logic             mem_write_i;
    logic             stall_i;
    logic             pc_src_o;
    logic             reg_write_o;
    logic             mem_write_o;
    logic             cond_ex_o;
    logic [3:0]       flags_o;
    logic [CNT_W-1:0] exec_count_o;
    logic [CNT_W-1:0] squash_count_o;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cond_i         (cond_i),
        .alu_flags_i    (alu_flags_i),
        .flag_write_i   (flag_write_i),
        .pc_src_i       (pc_src_i),
        .reg_write_i    (reg_write_i),
        .mem_write_i    (mem_write_i),
        .stall_i        (stall_i),
        .pc_src_o       (pc_src_o),
        .reg_write_o    (reg_write_o),
        .mem_write_o    (mem_write_o),
        .cond_ex_o      (cond_ex_o),
        .flags_o        (flags_o),
        .exec_count_o   (exec_count_o),
        .squash_count_o (squash_count_o)
    );

    always #5 clk_i = ~clk_i;

    int asserts  = 0;
    int failures = 0;

    // Reference state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       exp;
    } vec_t;

    vec_t vecs[64];

    // Conditions come in pairs: even code tests a predicate, odd code its negation.
    function automatic logic model_pass(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (code == 4'hF) return 1'b0;
        return code[0] ? !base : base;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] alu,
                         input logic pc, input logic rw, input logic mw);
        rst_i = rst; stall_i = stall; cond_i = cond; flag_write_i = fw;
        alu_flags_i = alu; pc_src_i = pc; reg_write_i = rw; mem_write_i = mw;
    endtask

    // One clock: check combinational outputs, step the model at the edge, check state.
    task automatic cycle();
        logic pass;
        logic go;
        #1;
        pass = model_pass(cond_i, m_flags);
        go   = pass && !stall_i;
        check("cond_ex", int'(cond_ex_o), int'(pass));
        check("pc_src",  int'(pc_src_o),  int'(pc_src_i && go));
        check("reg_wr",  int'(reg_write_o), int'(reg_write_i && go));
        check("mem_wr",  int'(mem_write_o), int'(mem_write_i && go));
        @(posedge clk_i);
        if (rst_i) begin
            m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        end else if (!stall_i) begin
            if (pass) begin
                if (flag_write_i[1]) m_flags[3:2] = alu_flags_i[3:2];
                if (flag_write_i[0]) m_flags[1:0] = alu_flags_i[1:0];
                if (m_exec < CNT_MAX) m_exec++;
            end else begin
                if (m_squash < CNT_MAX) m_squash++;
            end
        end
        #1;
        $display("cyc rst=%0b stall=%0b cond=%h fw=%b alu=%b -> flags=%b exec=%0d squash=%0d",
                 rst_i, stall_i, cond_i, flag_write_i, alu_flags_i, flags_o, exec_count_o, squash_count_o);
        check("flags",  int'(flags_o),        int'(m_flags));
        check("exec",   int'(exec_count_o),   m_exec);
        check("squash", int'(squash_count_o), m_squash);
    endtask

    task automatic load_flags(input logic [3:0] f);
        drive(1'b0, 1'b0, 4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        logic [3:0]  tbl_flags [4];
        logic [15:0] tbl_mask  [4];
        int prev_exec, prev_squash;
        logic [3:0] prev_flags;

        // Expected pass masks (bit k = outcome of condition code k) per flag set
        tbl_flags[0] = 4'b1001; tbl_mask[0] = 16'h565A;
        tbl_flags[1] = 4'b1000; tbl_mask[1] = 16'h6A9A;
        tbl_flags[2] = 4'b0100; tbl_mask[2] = 16'h66A9;
        tbl_flags[3] = 4'b0010; tbl_mask[3] = 16'h55A6;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 16; k++) begin
                vecs[t*16+k].cond  = k[3:0];
                vecs[t*16+k].flags = tbl_flags[t];
                vecs[t*16+k].exp   = tbl_mask[t][k];
            end
        end

        m_flags = 4'b0000; m_exec = 0; m_squash = 0;

        // Reset then idle
        drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("rst_flags",  int'(flags_o), 0);
        check("rst_exec",   int'(exec_count_o), 0);
        check("rst_squash", int'(squash_count_o), 0);
        drive(1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        #1 check("idle_eq", int'(cond_ex_o), 0);
        cycle();
        drive(1'b0, 1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        #1 check("idle_ne", int'(cond_ex_o), 1);
        cycle();

        // Split flag writes
        drive(1'b0, 1'b0, 4'hE, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0);
        cycle();
        check("split_nz", int'(flags_o), 4'b1100);
        drive(1'b0, 1'b0, 4'hE, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0);
        cycle();
        check("split_cv", int'(flags_o), 4'b1111);

        // Conditional squash with every strobe requested
        load_flags(4'b0100);
        prev_squash = int'(squash_count_o);
        drive(1'b0, 1'b0, 4'h1, 2'b11, 4'b1011, 1'b1, 1'b1, 1'b1);
        #1;
        check("sq_pc",  int'(pc_src_o), 0);
        check("sq_rw",  int'(reg_write_o), 0);
        check("sq_mw",  int'(mem_write_o), 0);
        cycle();
        check("sq_flags",  int'(flags_o), 4'b0100);
        check("sq_count",  int'(squash_count_o), prev_squash + 1);

        // Undefined write mask on squashed and stalled instructions
        drive(1'b0, 1'b0, 4'h1, 2'bxx, 4'b1111, 1'b0, 1'b0, 1'b0);
        cycle();
        check("x_squash_flags", int'(flags_o), 4'b0100);
        drive(1'b0, 1'b1, 4'hE, 2'bxx, 4'b1011, 1'b0, 1'b0, 1'b0);
        cycle();
        check("x_stall_flags", int'(flags_o), 4'b0100);

        // Condition-code table sweep
        foreach (vecs[i]) begin
            load_flags(vecs[i].flags);
            drive(1'b0, 1'b1, vecs[i].cond, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1);
            #1 check($sformatf("tbl_f%b_c%h", vecs[i].flags, vecs[i].cond),
                     int'(cond_ex_o), int'(vecs[i].exp));
            cycle();
        end

        // Stall freezes everything, then the instruction commits
        drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        load_flags(4'b0101);
        prev_flags = flags_o;
        prev_exec  = int'(exec_count_o);
        drive(1'b0, 1'b1, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b1, 1'b0);
        #1 check("stall_rw", int'(reg_write_o), 0);
        cycle();
        check("stall_flags", int'(flags_o), int'(prev_flags));
        check("stall_exec",  int'(exec_count_o), prev_exec);
        stall_i = 1'b0;
        #1 check("unstall_rw", int'(reg_write_o), 1);
        cycle();
        check("unstall_flags", int'(flags_o), 4'b1010);
        check("unstall_exec",  int'(exec_count_o), prev_exec + 1);

        // Randomized cycles
        for (int r = 0; r < 400; r++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                  4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end

        // Saturation then reset overriding stall
        drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int r = 0; r < 20; r++) begin
            drive(1'b0, 1'b0, 4'hE, 2'b11, 4'($urandom), 1'b0, 1'b1, 1'b0);
            cycle();
        end
        check("sat_exec",   int'(exec_count_o), CNT_MAX);
        check("sat_squash", int'(squash_count_o), 0);
        load_flags(4'b1111);
        drive(1'b1, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
        cycle();
        check("rstpri_flags",  int'(flags_o), 0);
        check("rstpri_exec",   int'(exec_count_o), 0);
        check("rstpri_squash", int'(squash_count_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
